// File: rtl/gravador_sequencia.sv
// ============================================================================
// gravador_sequencia
// ----------------------------------------------------------------------------
// Sequence recorder. After `iniciar`, every switch press (`chaves` going from
// 0000 to non-zero) is stored in a 16x4 RAM at the current position, and the
// position counter then advances. When the last position has been written,
// `pronto` pulses for one cycle and the FSM returns to idle. The playback /
// compare circuit reads the recorded sequence back through `le_endereco` /
// `le_dado`. The debug outputs are raw 4-bit values. The top level drives the
// 7-segment displays through hexa7seg.
//
// Parameters:
//   N_POS        positions recorded per session (1..16), default 16
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   iniciar      in   start a recording session (honoured only in INICIAL)
//   chaves[3:0]  in   switch inputs; a press is a 0000 -> non-zero transition
//   le_endereco  in   readback address
//   le_dado      out  RAM[le_endereco], combinational read
//   gravando     out  high while a session is in progress
//   pronto       out  one-cycle pulse when the session completes
//   db_invalida  out  one-cycle pulse when a press is rejected
//   db_contagem  out  current position counter
//   db_jogada    out  jogada register contents
//   db_estado    out  FSM state code
//
// Optional feature (macro GRAVADOR_ONEHOT_CHECK_EN):
//   When the macro is defined, a press in ESPERA whose value is not one-hot is
//   rejected. The FSM stays in ESPERA, nothing is written, and db_invalida
//   pulses. When the macro is undefined, any non-zero value is recorded and
//   db_invalida is tied to 0.
// ============================================================================
module gravador_sequencia #(
    parameter int N_POS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    input  logic [3:0] le_endereco,
    output logic [3:0] le_dado,
    output logic       gravando,
    output logic       pronto,
    output logic       db_invalida,
    output logic [3:0] db_contagem,
    output logic [3:0] db_jogada,
    output logic [3:0] db_estado
);

    // State codes are visible on db_estado, so the encoding is fixed.
    typedef enum logic [3:0] {
        INICIAL   = 4'h0,
        PREPARADO = 4'h1,
        ESPERA    = 4'h2,
        REGISTRA  = 4'h3,
        GRAVA     = 4'h4,
        PROXIMO   = 4'h5,
        FIM       = 4'hF
    } estado_t;

    // Counter value at which the last position is being written.
    localparam logic [3:0] ULTIMA_POS = 4'(N_POS - 1);

    estado_t    r_estado;
    estado_t    w_proximo_estado;

    logic [3:0] r_chaves_r;     // chaves, registered every cycle
    logic [3:0] r_chaves_p;     // r_chaves_r delayed by one cycle
    logic [3:0] r_jogada;
    logic [3:0] r_contagem;
    logic [3:0] r_mem [0:15];

    logic       w_press;
    logic       w_fim_c;
    logic       w_valida;
    logic       w_zera;
    logic       w_conta;
    logic       w_registra;
    logic       w_grava;
    logic       w_pronto;
    logic       w_gravando;
    logic       w_invalida;

    // ------------------------------------------------------------------
    // Press detection: a rising edge from 0000 to non-zero on the
    // registered switches. While the switches are held, r_chaves_p stays
    // non-zero, so a held press yields exactly one detection.
    // ------------------------------------------------------------------
    assign w_press = (r_chaves_r != 4'd0) && (r_chaves_p == 4'd0);
    assign w_fim_c = (r_contagem == ULTIMA_POS);

`ifdef GRAVADOR_ONEHOT_CHECK_EN
    // Exactly one switch active: non-zero, and clearing the lowest set bit
    // leaves zero.
    assign w_valida = (r_chaves_r != 4'd0) &&
                      ((r_chaves_r & (r_chaves_r - 4'd1)) == 4'd0);
`else
    assign w_valida = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo_estado;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_proximo_estado = r_estado;
        w_zera           = 1'b0;
        w_conta          = 1'b0;
        w_registra       = 1'b0;
        w_grava          = 1'b0;
        w_pronto         = 1'b0;
        w_gravando       = 1'b0;
        w_invalida       = 1'b0;

        case (r_estado)
            INICIAL: begin
                if (iniciar) begin
                    w_proximo_estado = PREPARADO;
                end
            end
            PREPARADO: begin
                w_gravando       = 1'b1;
                w_zera           = 1'b1;
                w_proximo_estado = ESPERA;
            end
            ESPERA: begin
                w_gravando = 1'b1;
                if (w_press) begin
                    if (w_valida) begin
                        w_proximo_estado = REGISTRA;
                    end else begin
                        // Rejected press: stay here. The one-cycle press
                        // pulse makes this a one-cycle flag.
                        w_invalida = 1'b1;
                    end
                end
            end
            REGISTRA: begin
                w_gravando       = 1'b1;
                w_registra       = 1'b1;
                w_proximo_estado = GRAVA;
            end
            GRAVA: begin
                w_gravando       = 1'b1;
                w_grava          = 1'b1;
                w_proximo_estado = w_fim_c ? FIM : PROXIMO;
            end
            PROXIMO: begin
                w_gravando       = 1'b1;
                w_conta          = 1'b1;
                w_proximo_estado = ESPERA;
            end
            FIM: begin
                w_pronto         = 1'b1;
                w_proximo_estado = INICIAL;
            end
            default: begin
                w_proximo_estado = INICIAL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chaves_r <= 4'd0;
            r_chaves_p <= 4'd0;
        end else begin
            r_chaves_r <= chaves;
            r_chaves_p <= r_chaves_r;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_jogada <= 4'd0;
        end else if (w_zera) begin
            r_jogada <= 4'd0;
        end else if (w_registra) begin
            r_jogada <= r_chaves_r;
        end
    end

    // The counter is cleared only in PREPARADO. Because N_POS <= 16, the
    // last increment happens at position N_POS-2, so it cannot wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contagem <= 4'd0;
        end else if (w_zera) begin
            r_contagem <= 4'd0;
        end else if (w_conta) begin
            r_contagem <= r_contagem + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sequence RAM
    // ------------------------------------------------------------------
    // NOTE: the RAM has no reset. Recorded sequences must survive reset,
    // and a memory without a reset maps onto plain RAM cells. A reset
    // during GRAVA forces the state to INICIAL before the next edge, so the
    // interrupted write is simply not performed.
    always_ff @(posedge clock) begin
        if (w_grava) begin
            r_mem[r_contagem] <= r_jogada;
        end
    end

    assign le_dado = r_mem[le_endereco];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gravando    = w_gravando;
    assign pronto      = w_pronto;
    assign db_invalida = w_invalida;
    assign db_contagem = r_contagem;
    assign db_jogada   = r_jogada;
    assign db_estado   = r_estado;

endmodule
